// File: rtl/gpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer: FSM state encoding,
// fetch stride and the {pc, bundle} entry layout held in the bundle FIFO.
package gpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned FETCH_BYTES = 8;
  localparam int unsigned BUNDLE_W    = 64;
  localparam int unsigned PC_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [BUNDLE_W-1:0] bundle;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head (data + valid) and a synchronous flush.
// A push is visible at the head one cycle later; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             valid_reg, valid_next;
  logic             push_fire, pop_fire;

  assign push_fire = push & ~flush;
  assign pop_fire  = pop & valid_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Next head: bypass the incoming word when it lands exactly in the new head slot.
  always_comb begin
    head_next  = '0;
    valid_next = 1'b0;
    if (count_next != '0) begin
      valid_next = 1'b1;
      if (push_fire && (wr_ptr_reg == rd_ptr_next)) head_next = push_data;
      else                                          head_next = mem_reg[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      valid_reg  <= valid_next;
    end
  end

  // Storage carries no reset so it can map onto memory primitives.
  always_ff @(posedge clk) begin
    if (push_fire) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data  = head_reg;
  assign head_valid = valid_reg;
  assign count      = count_reg;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch engine: single-outstanding imem requests feeding a bundle FIFO,
// with redirect/flush handling. Optional stall counter under macro IFB_PERF_CNT_EN.
module instr_fetch_buffer
  import gpu_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           start_pc,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [63:0]                 imem_rdata,
  output logic [63:0]                 instruction_bundle,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [ADDR_W-1:0]           head_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic [15:0]                 stall_cycles
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + BUNDLE_W;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic              imem_req_reg, imem_req_next;
  logic              gnt_fire, rsp_fire, push, pop, req_bubble;
  logic [CNT_W-1:0]  occ_next;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  assign gnt_fire   = (state_reg == REQ) && imem_req_reg && imem_gnt;
  assign rsp_fire   = ((state_reg == WAIT) || (state_reg == DRAIN)) && imem_rvalid;
  assign push       = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
  assign pop        = instr_valid && instr_ready;
  // A redirect before the grant retracts the request for one cycle.
  assign req_bubble = redirect_valid && (state_reg == REQ) && !gnt_fire;
  assign occ_next   = redirect_valid ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= '0;
      imem_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      imem_req_reg <= imem_req_next;
    end
  end

  // A response coinciding with a redirect closes the transaction, so no DRAIN is needed.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (redirect_valid || start) state_next = REQ;
      end
      REQ: begin
        if (gnt_fire) state_next = redirect_valid ? DRAIN : WAIT;
      end
      WAIT, DRAIN: begin
        if (rsp_fire)            state_next = REQ;
        else if (redirect_valid) state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_next = (state_next == REQ) && (occ_next < CNT_W'(FIFO_DEPTH)) && !req_bubble;
    busy          = (state_reg != IDLE);
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid)                     fetch_pc_next = redirect_pc;
    else if ((state_reg == IDLE) && start)  fetch_pc_next = start_pc;
    else if (push)                          fetch_pc_next = fetch_pc_reg + ADDR_W'(FETCH_BYTES);
  end

  // Entry layout mirrors fetch_entry_t: pc in the upper field, bundle below.
  assign push_entry = {fetch_pc_reg, imem_rdata};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_bundle_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (instr_ready),
    .head_data  (head_entry),
    .head_valid (instr_valid),
    .count      (fifo_count)
  );

  assign head_pc            = head_entry[ENTRY_W-1 -: ADDR_W];
  assign instruction_bundle = head_entry[BUNDLE_W-1:0];
  assign imem_req           = imem_req_reg;
  assign imem_addr          = fetch_pc_reg;

`ifdef IFB_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (instr_valid && !instr_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
